// File: rtl/conv_pkg.sv
// Shared defaults, derived sizes and FSM state type for the convolution stream driver.
package conv_pkg;

   localparam int unsigned DEF_DATA_WIDTH_X = 8;
   localparam int unsigned DEF_DATA_WIDTH_F = 8;
   localparam int unsigned DEF_X_SIZE       = 128;
   localparam int unsigned DEF_F_SIZE       = 32;
   localparam int unsigned DEF_ACC_SIZE     = 21;
   localparam int unsigned DEF_Y_SIZE       = DEF_X_SIZE - DEF_F_SIZE + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Address width that stays legal for single-entry buffers.
   function automatic int unsigned addr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_axis_src.sv
// Buffer-backed stream source: host-writable buffer streamed out in index order
// through a valid/ready master port while run is high.
module conv_axis_src
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 128,
   parameter int unsigned AW         = addr_w(DEPTH),
   parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [AW-1:0]                wr_addr,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   input  logic                         clear,
   input  logic                         run,
   output logic                         valid,
   input  logic                         ready,
   output logic signed [DATA_WIDTH-1:0] data,
   output logic                         finished
);

   logic signed [DATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [AW-1:0]                rd_idx;
   logic                         in_range;

   always_ff @(posedge clk) begin
      if (wr_en && (32'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      in_range = (cnt_q < CW'(DEPTH));
      valid    = run && in_range;
      finished = (cnt_q == CW'(DEPTH));
      rd_idx   = in_range ? cnt_q[AW-1:0] : '0;
      data     = mem[rd_idx];
   end

   // Index only moves on a handshake, so data is held across stalls.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (valid && ready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/conv_stream_driver.sv
// Streams X and F buffers to an external convolution engine and collects its Y
// results into a host-readable buffer, one run per start.
module conv_stream_driver
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_X = DEF_DATA_WIDTH_X,
   parameter int unsigned DATA_WIDTH_F = DEF_DATA_WIDTH_F,
   parameter int unsigned X_SIZE       = DEF_X_SIZE,
   parameter int unsigned F_SIZE       = DEF_F_SIZE,
   parameter int unsigned ACC_SIZE     = DEF_ACC_SIZE
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   wr_en_x,
   input  logic [addr_w(X_SIZE)-1:0]              wr_addr_x,
   input  logic signed [DATA_WIDTH_X-1:0]         wr_data_x,
   input  logic                                   wr_en_f,
   input  logic [addr_w(F_SIZE)-1:0]              wr_addr_f,
   input  logic signed [DATA_WIDTH_F-1:0]         wr_data_f,
   input  logic                                   start,
   input  logic                                   y_hold,
   output logic                                   m_valid_x,
   input  logic                                   m_ready_x,
   output logic signed [DATA_WIDTH_X-1:0]         m_data_x,
   output logic                                   m_valid_f,
   input  logic                                   m_ready_f,
   output logic signed [DATA_WIDTH_F-1:0]         m_data_f,
   input  logic                                   s_valid_y,
   output logic                                   s_ready_y,
   input  logic signed [ACC_SIZE-1:0]             s_data_y,
   input  logic [addr_w(X_SIZE-F_SIZE+1)-1:0]     rd_addr_y,
   output logic [ACC_SIZE-1:0]                    rd_data_y,
   output logic                                   busy,
   output logic                                   done,
   output logic [$clog2(X_SIZE-F_SIZE+2)-1:0]     y_count
);

   localparam int unsigned Y_SIZE = X_SIZE - F_SIZE + 1;
   localparam int unsigned YAW    = addr_w(Y_SIZE);
   localparam int unsigned YCW    = $clog2(Y_SIZE + 1);

   state_t             state_q, state_d;
   logic [YCW-1:0]     y_cnt_q, y_cnt_d;
   logic [ACC_SIZE-1:0] ybuf [Y_SIZE];
   logic               clear;
   logic               running;
   logic               x_fin, f_fin;
   logic               y_fire;

   assign running = (state_q == RUN);
   assign clear   = (state_q == IDLE) && start;

   conv_axis_src #(
      .DATA_WIDTH (DATA_WIDTH_X),
      .DEPTH      (X_SIZE)
   ) u_src_x (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_x && !busy),
      .wr_addr  (wr_addr_x),
      .wr_data  (wr_data_x),
      .clear    (clear),
      .run      (running),
      .valid    (m_valid_x),
      .ready    (m_ready_x),
      .data     (m_data_x),
      .finished (x_fin)
   );

   conv_axis_src #(
      .DATA_WIDTH (DATA_WIDTH_F),
      .DEPTH      (F_SIZE)
   ) u_src_f (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_f && !busy),
      .wr_addr  (wr_addr_f),
      .wr_data  (wr_data_f),
      .clear    (clear),
      .run      (running),
      .valid    (m_valid_f),
      .ready    (m_ready_f),
      .data     (m_data_f),
      .finished (f_fin)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (x_fin && f_fin && (y_cnt_q == YCW'(Y_SIZE))) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         y_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         y_cnt_q <= y_cnt_d;
      end
   end

   // Y beats are accepted as soon as the engine offers them, independent of X/F progress.
   always_comb begin
      s_ready_y = running && !y_hold && (y_cnt_q < YCW'(Y_SIZE));
      y_fire    = s_valid_y && s_ready_y;
      y_cnt_d   = y_cnt_q;
      if (clear) begin
         y_cnt_d = '0;
      end else if (y_fire) begin
         y_cnt_d = y_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (y_fire) begin
         ybuf[y_cnt_q[YAW-1:0]] <= s_data_y;
      end
   end

   always_comb begin
      rd_data_y = (32'(rd_addr_y) < Y_SIZE) ? ybuf[rd_addr_y] : '0;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      y_count   = y_cnt_q;
   end

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench: models the external convolution engine (correlation of the
// received X and F streams) and checks the driver with hand-computed results.
module tb_conv_stream_driver;

   localparam int XS  = 128;
   localparam int FS  = 32;
   localparam int YS  = 97;
   localparam int ACC = 21;

   logic               clk = 1'b0;
   logic               reset;
   logic               wr_en_x, wr_en_f;
   logic [6:0]         wr_addr_x;
   logic [4:0]         wr_addr_f;
   logic signed [7:0]  wr_data_x, wr_data_f;
   logic               start, y_hold;
   logic               m_valid_x, m_ready_x, m_valid_f, m_ready_f;
   logic signed [7:0]  m_data_x, m_data_f;
   logic               s_valid_y, s_ready_y;
   logic signed [ACC-1:0] s_data_y;
   logic [6:0]         rd_addr_y;
   logic [ACC-1:0]     rd_data_y;
   logic               busy, done;
   logic [6:0]         y_count;

   int tests = 0;
   int fails = 0;

   conv_stream_driver dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en_x   (wr_en_x),
      .wr_addr_x (wr_addr_x),
      .wr_data_x (wr_data_x),
      .wr_en_f   (wr_en_f),
      .wr_addr_f (wr_addr_f),
      .wr_data_f (wr_data_f),
      .start     (start),
      .y_hold    (y_hold),
      .m_valid_x (m_valid_x),
      .m_ready_x (m_ready_x),
      .m_data_x  (m_data_x),
      .m_valid_f (m_valid_f),
      .m_ready_f (m_ready_f),
      .m_data_f  (m_data_f),
      .s_valid_y (s_valid_y),
      .s_ready_y (s_ready_y),
      .s_data_y  (s_data_y),
      .rd_addr_y (rd_addr_y),
      .rd_data_y (rd_data_y),
      .busy      (busy),
      .done      (done),
      .y_count   (y_count)
   );

   always #5 clk = ~clk;

   // Engine model: capture transfers at the edge, offer Y beats from the negedge.
   logic signed [7:0] xr [256];
   logic signed [7:0] fr [256];
   logic signed [7:0] fv [FS];
   int xn = 0, fn = 0, yk = 0, done_cnt = 0;
   logic signed [7:0] px, pf;
   bit hx = 0, hf = 0, stall_bad = 0;
   int stall_seen = 0;

   always @(posedge clk) begin
      if (done) done_cnt++;
      if (hx && (!m_valid_x || m_data_x !== px)) stall_bad = 1;
      if (hf && (!m_valid_f || m_data_f !== pf)) stall_bad = 1;
      hx = reset && m_valid_x && !m_ready_x;
      hf = reset && m_valid_f && !m_ready_f;
      if (hx || hf) stall_seen++;
      px = m_data_x;
      pf = m_data_f;
      if (start && !busy) begin
         xn = 0; fn = 0; yk = 0;
      end else begin
         if (m_valid_x && m_ready_x && xn < 256) begin xr[xn] = m_data_x; xn++; end
         if (m_valid_f && m_ready_f && fn < 256) begin fr[fn] = m_data_f; fn++; end
         if (s_valid_y && s_ready_y) yk++;
      end
   end

   always @(negedge clk) begin
      int acc;
      acc = 0;
      if (yk < YS && fn == FS && xn >= yk + FS) begin
         for (int j = 0; j < FS; j++) acc += int'(xr[yk + j]) * int'(fr[j]);
         s_valid_y = 1'b1;
      end else begin
         s_valid_y = 1'b0;
      end
      s_data_y = acc[ACC-1:0];
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // kind 0: all ones; 1: x=i, f=impulse; 2: all -128
   task automatic load(input int kind);
      for (int i = 0; i < XS; i++) begin
         @(negedge clk);
         wr_en_x   = 1'b1;
         wr_addr_x = 7'(i);
         wr_data_x = (kind == 0) ? 8'sd1 : (kind == 1) ? 8'(i) : -8'sd128;
         wr_en_f   = (i < FS);
         wr_addr_f = 5'(i);
         wr_data_f = (kind == 0) ? 8'sd1 : (kind == 1) ? ((i == 0) ? 8'sd1 : 8'sd0) : -8'sd128;
         if (i < FS) fv[i] = wr_data_f;
      end
      @(negedge clk);
      wr_en_x = 1'b0;
      wr_en_f = 1'b0;
   endtask

   // mode 0: all ready; 1: X toggles, F stalls 20 cycles; 2: y_hold burst; 3: start/writes mid-run
   task automatic run_job(input int mode);
      int  cyc;
      int  yk_hold;
      bit  seen;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0; seen = 0; yk_hold = 0;
      while (!seen && cyc < 3000) begin
         case (mode)
            1: begin m_ready_x = cyc[0]; m_ready_f = (cyc >= 20); end
            2: y_hold = (cyc >= 60 && cyc < 70);
            3: begin
               start   = (cyc == 2);
               wr_en_x = (cyc == 2); wr_addr_x = 7'd3;  wr_data_x = 8'sd7;
               wr_en_f = (cyc == 2); wr_addr_f = 5'd31; wr_data_f = 8'sd7;
            end
            default: ;
         endcase
         #1;
         if (mode == 2 && cyc == 60) yk_hold = yk;
         if (mode == 2 && cyc == 65) check("yhold_ready_low", 32'(s_ready_y), 32'd0);
         if (mode == 2 && cyc == 69) check("yhold_no_accept", 32'(yk), 32'(yk_hold));
         if (done) seen = 1;
         else begin @(negedge clk); cyc++; end
      end
      check("done_reached", 32'(seen), 32'd1);
      m_ready_x = 1'b1; m_ready_f = 1'b1; y_hold = 1'b0; start = 1'b0;
      wr_en_x = 1'b0; wr_en_f = 1'b0;
   endtask

   task automatic check_y(input string tag, input int kind);
      int bad;
      int exp;
      bad = 0;
      for (int k = 0; k < YS; k++) begin
         rd_addr_y = 7'(k);
         #1;
         exp = (kind == 0) ? 32 : (kind == 1) ? k : 524288;
         if (rd_data_y !== ACC'(exp)) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      int bad, d0, cyc;
      reset = 1'b0; start = 1'b0; y_hold = 1'b0;
      wr_en_x = 1'b0; wr_en_f = 1'b0; wr_addr_x = '0; wr_addr_f = '0;
      wr_data_x = '0; wr_data_f = '0; m_ready_x = 1'b1; m_ready_f = 1'b1;
      rd_addr_y = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid_x", 32'(m_valid_x), 32'd0);
      check("rst_valid_f", 32'(m_valid_f), 32'd0);
      check("rst_ready_y", 32'(s_ready_y), 32'd0);
      check("rst_y_count", 32'(y_count), 32'd0);
      reset = 1'b1;

      // All-ones run: every output is the F length.
      load(0);
      d0 = done_cnt;
      run_job(0);
      check("ones_y_count", 32'(y_count), 32'd97);
      start = 1'b1;                               // start during DONE must be ignored
      @(negedge clk); start = 1'b0; #1;
      check("done_start_ignored", 32'(busy), 32'd0);
      check("ones_done_once", 32'(done_cnt - d0), 32'd1);
      check("ones_done_low", 32'(done), 32'd0);
      check("ones_x_xfers", 32'(xn), 32'd128);
      check("ones_f_xfers", 32'(fn), 32'd32);
      repeat (3) @(negedge clk);
      check("ones_y_count_hold", 32'(y_count), 32'd97);
      check_y("ones_ybuf", 0);

      // Ramp with impulse filter: y[k] = k.
      load(1);
      run_job(0);
      check_y("ramp_ybuf", 1);
      rd_addr_y = 7'd96; #1;
      check("ramp_y96", 32'(rd_data_y), 32'd96);

      // Backpressure on both masters.
      run_job(1);
      bad = 0;
      for (int i = 0; i < XS; i++) if (xr[i] !== 8'(i)) bad++;
      for (int j = 0; j < FS; j++) if (fr[j] !== fv[j]) bad++;
      check("stall_order", 32'(bad), 32'd0);
      check("stall_x_xfers", 32'(xn), 32'd128);
      check("stall_seen", 32'(stall_seen > 0), 32'd1);
      check("stall_data_stable", 32'(stall_bad), 32'd0);
      check_y("stall_ybuf", 1);

      // Host throttle on Y.
      run_job(2);
      check("yhold_y_count", 32'(y_count), 32'd97);
      check_y("yhold_ybuf", 1);

      // Full negative range, with start and host writes attempted mid-run.
      load(2);
      run_job(3);
      check("neg_y_count", 32'(y_count), 32'd97);
      check("neg_x_xfers", 32'(xn), 32'd128);
      check_y("neg_ybuf", 2);

      // Abort mid-run via reset, then restart from index 0.
      load(1);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (xn != 50 && cyc < 500) begin @(negedge clk); cyc++; end
      check("abort_reached_50", 32'(xn), 32'd50);
      check("abort_data_50", 32'(m_data_x), 32'(8'd50));
      reset = 1'b0; #1;
      check("abort_valid_x", 32'(m_valid_x), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready_y", 32'(s_ready_y), 32'd0);
      @(negedge clk);
      check("abort_y_count", 32'(y_count), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      wr_en_x = 1'b1; wr_addr_x = 7'd0; wr_data_x = 8'sd5;
      @(negedge clk); wr_en_x = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; #1;
      check("restart_first_data", 32'(m_data_x), 32'(8'd5));
      run_job(0);
      check("restart_first_xfer", 32'(xr[0]), 32'(8'd5));
      check("restart_x_xfers", 32'(xn), 32'd128);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/conv_stream_driver.md
CONV_STREAM_DRIVER -- requirements
Module: conv_stream_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH_X, default 8, X sample width.
REQ-002 SHALL have parameter DATA_WIDTH_F, default 8, filter coefficient width.
REQ-003 SHALL have parameter X_SIZE, default 128, X vector length.
REQ-004 SHALL have parameter F_SIZE, default 32, F vector length.
REQ-005 SHALL have parameter ACC_SIZE, default 21, Y result width; derived Y_SIZE = X_SIZE-F_SIZE+1 (97).
REQ-006 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-007 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports: wr_en_x  in  1; wr_addr_x  in  clog2(X_SIZE); wr_data_x  in  DATA_WIDTH_X signed: host write into X buffer.
REQ-009 SHALL have ports: wr_en_f  in  1; wr_addr_f  in  clog2(F_SIZE); wr_data_f  in  DATA_WIDTH_F signed: host write into F buffer.
REQ-010 SHALL have ports: start  in  1  begin run; y_hold  in  1  host throttle on Y acceptance.
REQ-011 SHALL have ports: m_valid_x  out  1; m_ready_x  in  1; m_data_x  out  DATA_WIDTH_X signed: X stream master.
REQ-012 SHALL have ports: m_valid_f  out  1; m_ready_f  in  1; m_data_f  out  DATA_WIDTH_F signed: F stream master.
REQ-013 SHALL have ports: s_valid_y  in  1; s_ready_y  out  1; s_data_y  in  ACC_SIZE signed: Y stream slave.
REQ-014 SHALL have ports: rd_addr_y  in  clog2(Y_SIZE); rd_data_y  out  ACC_SIZE: combinational read of Y buffer.
REQ-015 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; y_count  out  clog2(Y_SIZE+1).

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when x_cnt==X_SIZE, f_cnt==F_SIZE and y_cnt==Y_SIZE; DONE -> IDLE after exactly one cycle.
REQ-017 SHALL ignore start outside IDLE, and ignore wr_en_x/wr_en_f while busy (busy = state != IDLE).
REQ-018 SHALL, in RUN, assert m_valid_x while x_cnt<X_SIZE with m_data_x = xbuf[x_cnt]; transfer and x_cnt increment only on m_valid_x && m_ready_x.
REQ-019 SHALL run the F channel identically and independently of X (f_cnt, fbuf, m_valid_f, m_ready_f).
REQ-020 SHALL hold m_data_x/m_data_f stable while valid && !ready; valid never deasserts before its transfer.
REQ-021 SHALL drive s_ready_y = (state==RUN) && !y_hold && y_cnt<Y_SIZE; on s_valid_y && s_ready_y write s_data_y to ybuf[y_cnt] and increment y_cnt.
REQ-022 SHALL accept Y beats in RUN even before both X and F channels finish.
REQ-023 SHALL clear x_cnt, f_cnt, y_cnt on the IDLE->RUN transition; y_count SHALL reflect y_cnt and hold its final value after DONE until next start.
REQ-024 SHALL assert done for exactly the DONE cycle; done and start in same cycle SHALL not start a new run.
REQ-025 SHALL not modify buffer contents except via host writes (X/F) and accepted Y beats.

Reset
REQ-026 SHALL, on reset low, immediately force state IDLE, counters 0, m_valid_x=0, m_valid_f=0, s_ready_y=0, busy=0, done=0, independent of clk.
REQ-027 SHALL leave X/F/Y buffer contents unreset; reset mid-RUN aborts, next start restreams from index 0.

Structure
REQ-028 SHALL place DATA_WIDTH/SIZE defaults, Y_SIZE derivation and FSM state enum (IDLE, RUN, DONE) in shared package conv_pkg.
REQ-029 SHALL implement each master channel as one instance of sub-module conv_axis_src (buffer-indexed counter plus valid/ready), instantiated for X and F.

Verification
REQ-030 SHALL cover: X all 1, F all 1, m_ready/y always ready -> 97 Y beats each 32, done pulse once, y_count=97.
REQ-031 SHALL cover: x[i]=i, F=[1,0,...,0] -> ybuf[k]=k for k=0..96.
REQ-032 SHALL cover: m_ready_x toggling every cycle, m_ready_f low 20 cycles -> 128/32 transfers in order, data stable during stalls.
REQ-033 SHALL cover: y_hold high for 10 cycles mid-stream -> s_ready_y low, no Y beat lost, final y_count=97.
REQ-034 SHALL cover: reset low at x_cnt=50 -> m_valid_x=0 same cycle, busy=0; restart resends xbuf[0] first.
REQ-035 SHALL cover: all X=-128, all F=-128 -> every Y = 524288; start and host writes during RUN ignored.
